// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writeback.
// Outputs are registered on posedge so the falling-edge register file sees stable values.
module regfile_write_arbiter #(
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 4,
  parameter bit R0_PROTECT = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              reqA_valid,
  input  logic [ADDR_W-1:0] reqA_addr,
  input  logic [DATA_W-1:0] reqA_data,
  output logic              reqA_ready,
  input  logic              reqB_valid,
  input  logic [ADDR_W-1:0] reqB_addr,
  input  logic [DATA_W-1:0] reqB_data,
  output logic              reqB_ready,
  output logic [ADDR_W-1:0] RegWriteAdress,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              grant_a;
  logic              grant_b;
  logic              both_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;

  // last_grant=1 means B went last, so A holds priority on a conflict.
  always_comb begin
    both_valid = reqA_valid && reqB_valid;
    grant_a    = resetn && reqA_valid && (!reqB_valid || last_grant);
    grant_b    = resetn && reqB_valid && (!reqA_valid || !last_grant);
    reqA_ready = grant_a;
    reqB_ready = grant_b;
    sel_addr   = grant_b ? reqB_addr : reqA_addr;
    sel_data   = grant_b ? reqB_data : reqA_data;
    sel_we     = !(R0_PROTECT && (sel_addr == '0));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      RegWriteAdress <= '0;
      WriteData      <= '0;
      WriteEnable    <= 1'b0;
      last_grant     <= 1'b1;
      conflict_count <= '0;
    end else begin
      if (grant_a || grant_b) begin
        RegWriteAdress <= sel_addr;
        WriteData      <= sel_data;
        WriteEnable    <= sel_we;
        last_grant     <= grant_b;
      end else begin
        WriteEnable    <= 1'b0;
      end
      if (both_valid && (conflict_count != CNT_MAX)) begin
        conflict_count <= conflict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with a scoreboard queue and a falling-edge register file model.
// A second instance with R0_PROTECT=1 shares the stimulus to cover the read-only register 0.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        resetn;
  logic        reqA_valid;
  logic [3:0]  reqA_addr;
  logic [19:0] reqA_data;
  logic        reqB_valid;
  logic [3:0]  reqB_addr;
  logic [19:0] reqB_data;

  logic        a_ready, b_ready, we;
  logic [3:0]  waddr;
  logic [19:0] wdata;
  logic        lg;
  logic [7:0]  cnt;

  logic        a_ready_p, b_ready_p, we_p;
  logic [3:0]  waddr_p;
  logic [19:0] wdata_p;
  logic        lg_p;
  logic [7:0]  cnt_p;

  logic [19:0] regs   [16];
  logic [19:0] regs_p [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic        av;
    logic [3:0]  aa;
    logic [19:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [19:0] bd;
    logic        ear;
    logic        ebr;
    logic        ewe;
    logic        ewe_p;
    logic [3:0]  eaddr;
    logic [19:0] edata;
    logic        elg;
    logic [7:0]  ecnt;
  } vec_t;

  typedef struct {
    logic        we;
    logic        we_p;
    logic [3:0]  addr;
    logic [19:0] data;
    logic        lg;
    logic [7:0]  cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  regfile_write_arbiter #(.DATA_W(20), .ADDR_W(4), .R0_PROTECT(1'b0), .CNT_W(8)) dut (
    .clock(clock), .resetn(resetn),
    .reqA_valid(reqA_valid), .reqA_addr(reqA_addr), .reqA_data(reqA_data), .reqA_ready(a_ready),
    .reqB_valid(reqB_valid), .reqB_addr(reqB_addr), .reqB_data(reqB_data), .reqB_ready(b_ready),
    .RegWriteAdress(waddr), .WriteData(wdata), .WriteEnable(we),
    .last_grant(lg), .conflict_count(cnt)
  );

  regfile_write_arbiter #(.DATA_W(20), .ADDR_W(4), .R0_PROTECT(1'b1), .CNT_W(8)) dut_p (
    .clock(clock), .resetn(resetn),
    .reqA_valid(reqA_valid), .reqA_addr(reqA_addr), .reqA_data(reqA_data), .reqA_ready(a_ready_p),
    .reqB_valid(reqB_valid), .reqB_addr(reqB_addr), .reqB_data(reqB_data), .reqB_ready(b_ready_p),
    .RegWriteAdress(waddr_p), .WriteData(wdata_p), .WriteEnable(we_p),
    .last_grant(lg_p), .conflict_count(cnt_p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The register file commits on the falling edge.
  initial begin
    for (int i = 0; i < 16; i++) begin
      regs[i]   = '0;
      regs_p[i] = '0;
    end
  end
  always @(negedge clock) begin
    if (we)   regs[waddr]     <= wdata;
    if (we_p) regs_p[waddr_p] <= wdata_p;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic rstn, input logic av, input logic [3:0] aa, input logic [19:0] ad,
                        input logic bv, input logic [3:0] ba, input logic [19:0] bd,
                        input logic ear, input logic ebr, input logic ewe, input logic ewe_p,
                        input logic [3:0] eaddr, input logic [19:0] edata, input logic elg,
                        input logic [7:0] ecnt);
    vec_t v;
    v.rstn = rstn; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ewe_p = ewe_p;
    v.eaddr = eaddr; v.edata = edata; v.elg = elg; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clock);
    resetn     = v.rstn;
    reqA_valid = v.av;
    reqA_addr  = v.aa;
    reqA_data  = v.ad;
    reqB_valid = v.bv;
    reqB_addr  = v.ba;
    reqB_data  = v.bd;
    #1;
    checkVal("reqA_ready", {31'b0, a_ready}, {31'b0, v.ear});
    checkVal("reqB_ready", {31'b0, b_ready}, {31'b0, v.ebr});
    checkVal("reqA_ready_p", {31'b0, a_ready_p}, {31'b0, v.ear});
    checkVal("reqB_ready_p", {31'b0, b_ready_p}, {31'b0, v.ebr});
    e.we = v.ewe; e.we_p = v.ewe_p; e.addr = v.eaddr; e.data = v.edata;
    e.lg = v.elg; e.cnt = v.ecnt;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkVal("WriteEnable", {31'b0, we}, {31'b0, e.we});
      checkVal("WriteEnable_p", {31'b0, we_p}, {31'b0, e.we_p});
      checkVal("RegWriteAdress", {28'b0, waddr}, {28'b0, e.addr});
      checkVal("WriteData", {12'b0, wdata}, {12'b0, e.data});
      checkVal("last_grant", {31'b0, lg}, {31'b0, e.lg});
      checkVal("conflict_count", {24'b0, cnt}, {24'b0, e.cnt});
    end
  endtask

  initial begin
    logic       exp_lg;
    logic [7:0] exp_cnt;
    logic       ga;
    vec_t       v;

    resetn = 1'b0; reqA_valid = 1'b0; reqA_addr = '0; reqA_data = '0;
    reqB_valid = 1'b0; reqB_addr = '0; reqB_data = '0;

    //     rstn av aa   ad        bv ba   bd        ear ebr we wep addr  data      lg cnt
    addVec(0,  1, 4'd5, 20'h00009, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd0, 20'h00000, 1, 8'd0);
    addVec(0,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd0, 20'h00000, 1, 8'd0);
    addVec(1,  1, 4'd3, 20'h00005, 0, 4'd0, 20'h0,     1, 0, 1, 1, 4'd3, 20'h00005, 0, 8'd0);
    addVec(1,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd3, 20'h00005, 0, 8'd0);
    addVec(1,  0, 4'd0, 20'h00000, 1, 4'd9, 20'h00099, 0, 1, 1, 1, 4'd9, 20'h00099, 1, 8'd0);
    addVec(1,  1, 4'd1, 20'h00011, 1, 4'd2, 20'h00022, 1, 0, 1, 1, 4'd1, 20'h00011, 0, 8'd1);
    addVec(1,  1, 4'd1, 20'h00011, 1, 4'd2, 20'h00022, 0, 1, 1, 1, 4'd2, 20'h00022, 1, 8'd2);
    addVec(1,  1, 4'd1, 20'h00011, 1, 4'd2, 20'h00022, 1, 0, 1, 1, 4'd1, 20'h00011, 0, 8'd3);
    addVec(1,  1, 4'd1, 20'h00011, 1, 4'd2, 20'h00022, 0, 1, 1, 1, 4'd2, 20'h00022, 1, 8'd4);
    addVec(1,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd2, 20'h00022, 1, 8'd4);
    addVec(1,  1, 4'd7, 20'hAAAAA, 1, 4'd7, 20'h55555, 1, 0, 1, 1, 4'd7, 20'hAAAAA, 0, 8'd5);
    addVec(1,  0, 4'd7, 20'hAAAAA, 1, 4'd7, 20'h55555, 0, 1, 1, 1, 4'd7, 20'h55555, 1, 8'd5);
    addVec(1,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd7, 20'h55555, 1, 8'd5);
    addVec(1,  0, 4'd0, 20'h00000, 1, 4'd0, 20'hFFFFF, 0, 1, 1, 0, 4'd0, 20'hFFFFF, 1, 8'd5);
    addVec(1,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd0, 20'hFFFFF, 1, 8'd5);
    addVec(1,  1, 4'd4, 20'h00044, 1, 4'd5, 20'h00055, 1, 0, 1, 1, 4'd4, 20'h00044, 0, 8'd6);
    addVec(1,  0, 4'd0, 20'h00000, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd4, 20'h00044, 0, 8'd6);
    addVec(0,  1, 4'd6, 20'h00066, 0, 4'd0, 20'h0,     0, 0, 0, 0, 4'd0, 20'h00000, 1, 8'd0);
    addVec(1,  1, 4'd6, 20'h00066, 0, 4'd0, 20'h0,     1, 0, 1, 1, 4'd6, 20'h00066, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
      if (i == 3) checkVal("regfile_r3", {12'b0, regs[3]}, 32'h00005);
    end

    // Both requesters held valid long enough to saturate the 8-bit conflict counter.
    exp_lg  = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      ga = exp_lg;
      exp_lg  = ~ga;
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      v.rstn = 1'b1;
      v.av = 1'b1; v.aa = 4'd10; v.ad = 20'hA0A0A;
      v.bv = 1'b1; v.ba = 4'd11; v.bd = 20'hB0B0B;
      v.ear = ga; v.ebr = ~ga; v.ewe = 1'b1; v.ewe_p = 1'b1;
      v.eaddr = ga ? 4'd10 : 4'd11;
      v.edata = ga ? 20'hA0A0A : 20'hB0B0B;
      v.elg = exp_lg; v.ecnt = exp_cnt;
      applyStimulus(v);
      checkOutput();
    end

    @(negedge clock);
    reqA_valid = 1'b0;
    reqB_valid = 1'b0;
    @(negedge clock);
    #1;
    checkVal("conflict_count_sat", {24'b0, cnt}, 32'd255);
    checkVal("regfile_r1", {12'b0, regs[1]}, 32'h00011);
    checkVal("regfile_r2", {12'b0, regs[2]}, 32'h00022);
    checkVal("regfile_r7", {12'b0, regs[7]}, 32'h55555);
    checkVal("regfile_r0_unprot", {12'b0, regs[0]}, 32'hFFFFF);
    checkVal("regfile_r0_prot", {12'b0, regs_p[0]}, 32'h00000);
    checkVal("regfile_r6", {12'b0, regs[6]}, 32'h00066);
    checkVal("regfile_r10", {12'b0, regs[10]}, 32'hA0A0A);
    checkVal("regfile_r11", {12'b0, regs[11]}, 32'hB0B0B);
    checkVal("regfile_r5_untouched", {12'b0, regs[5]}, 32'h00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
